// File: rtl/jk_drv_pkg.sv
// Shared state encoding, command codes and latch-behaviour helper for the JK drive sequencer.
package jk_drv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    localparam logic [1:0] CMD_HOLD   = 2'b00;
    localparam logic [1:0] CMD_RESET  = 2'b01;
    localparam logic [1:0] CMD_SET    = 2'b10;
    localparam logic [1:0] CMD_TOGGLE = 2'b11;

    // Latch q after one enable pulse with the given {j,k}
    function automatic logic jk_next_q(input logic q, input logic [1:0] c);
        logic r;
        case (c)
            CMD_RESET:  r = 1'b0;
            CMD_SET:    r = 1'b1;
            CMD_TOGGLE: r = ~q;
            default:    r = q;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Power-of-two command buffer for 2-bit {j,k} commands; pointers wrap naturally.
module jk_cmd_fifo
    import jk_drv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [1:0] wdata_i,
    output logic [1:0] rdata_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [1:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push_s;
    logic          do_pop_s;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;
    assign rdata_o   = mem_q[rd_ptr_q];

    // Storage, pointers and occupancy; push and pop in one cycle cancel in the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= CMD_HOLD;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/jk_drive_sequencer.sv
// Sequences buffered {j,k} commands into setup/enable-pulse/hold waveforms for a JK latch.
// Optional latch prediction on q_model is built only when JK_DRV_MODEL_EN is defined.
module jk_drive_sequencer
    import jk_drv_pkg::*;
#(
    parameter int SETUP_CYCLES = 1,
    parameter int PULSE_CYCLES = 2,
    parameter int HOLD_CYCLES  = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    output logic       cmd_ready,
    output logic       j,
    output logic       k,
    output logic       enable,
    output logic       busy,
    output logic       q_model
);

    localparam logic [3:0] SETUP_LOAD = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] PULSE_LOAD = 4'(PULSE_CYCLES - 1);
    localparam logic [3:0] HOLD_LOAD  = 4'(HOLD_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] cmd_q, cmd_d;
    logic       j_q, j_d;
    logic       k_q, k_d;
    logic       en_q, en_d;
    logic       rdy_q;
    logic       push_s;
    logic       pop_s;
    logic       fifo_full_s;
    logic       fifo_empty_s;
    logic [1:0] fifo_rdata_s;

    assign cmd_ready = rdy_q && !fifo_full_s;
    assign push_s    = cmd_valid && cmd_ready;
    assign busy      = !fifo_empty_s || (state_q != ST_IDLE);
    assign j         = j_q;
    assign k         = k_q;
    assign enable    = en_q;

    jk_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .wdata_i (cmd),
        .rdata_o (fifo_rdata_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Next-state and next-output logic; counters count down to zero in each phase
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        j_d     = j_q;
        k_d     = k_q;
        en_d    = en_q;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                j_d  = 1'b0;
                k_d  = 1'b0;
                en_d = 1'b0;
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    cmd_d   = fifo_rdata_s;
                    j_d     = fifo_rdata_s[1];
                    k_d     = fifo_rdata_s[0];
                    cnt_d   = SETUP_LOAD;
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_PULSE;
                    en_d    = 1'b1;
                    // A toggle held enabled for more than one cycle would let the latch oscillate
                    cnt_d   = (cmd_q == CMD_TOGGLE) ? 4'd0 : PULSE_LOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_PULSE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_HOLD;
                    en_d    = 1'b0;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                    j_d     = 1'b0;
                    k_d     = 1'b0;
                    en_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                j_d     = 1'b0;
                k_d     = 1'b0;
                en_d    = 1'b0;
            end
        endcase
    end

    // FSM and output registers; rdy_q holds cmd_ready low until the first edge after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            cmd_q   <= CMD_HOLD;
            j_q     <= 1'b0;
            k_q     <= 1'b0;
            en_q    <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            j_q     <= j_d;
            k_q     <= k_d;
            en_q    <= en_d;
            rdy_q   <= 1'b1;
        end
    end

`ifdef JK_DRV_MODEL_EN
    logic q_model_q;
    logic q_upd_s;

    assign q_upd_s = (state_q == ST_PULSE) && (cnt_q == 4'd0);
    assign q_model = q_model_q;

    // Predicted latch state, advanced as the enable pulse ends
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_model_q <= 1'b0;
        end else if (q_upd_s) begin
            q_model_q <= jk_next_q(q_model_q, cmd_q);
        end else begin
            q_model_q <= q_model_q;
        end
    end
`else
    assign q_model = 1'b0;
`endif

endmodule

// File: tb/tb_jk_drive_sequencer.sv
// Randomized bench: a queue-based waveform model predicts every output cycle by cycle.
module tb_jk_drive_sequencer;

    localparam int TB_SETUP = 1;
    localparam int TB_PULSE = 3;
    localparam int TB_HOLD  = 2;
    localparam int TB_DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic       cmd_ready, j, k, enable, busy, q_model;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: pending commands, expected per-cycle outputs {active,q,j,k,en}
    logic [1:0] m_fifo[$];
    logic [4:0] m_wave[$];
    logic [4:0] m_cur;
    logic       m_q;
    logic       m_rdy;

    always #5 clk = ~clk;

    jk_drive_sequencer #(
        .SETUP_CYCLES (TB_SETUP),
        .PULSE_CYCLES (TB_PULSE),
        .HOLD_CYCLES  (TB_HOLD),
        .FIFO_DEPTH   (TB_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_ready (cmd_ready),
        .j         (j),
        .k         (k),
        .enable    (enable),
        .busy      (busy),
        .q_model   (q_model)
    );

    task automatic check_eq(input string tag, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic latch_after(input logic q, input logic [1:0] c);
        if (c == 2'b01) return 1'b0;
        else if (c == 2'b10) return 1'b1;
        else if (c == 2'b11) return ~q;
        else return q;
    endfunction

    task automatic m_reset();
        m_fifo.delete();
        m_wave.delete();
        m_q   = 1'b0;
        m_rdy = 1'b0;
        m_cur = 5'b00000;
    endtask

    task automatic m_expand(input logic [1:0] c);
        int   plen;
        logic nq;
        plen = (c == 2'b11) ? 1 : TB_PULSE;
`ifdef JK_DRV_MODEL_EN
        nq = latch_after(m_q, c);
`else
        nq = 1'b0;
`endif
        repeat (TB_SETUP) m_wave.push_back({1'b1, m_q, c, 1'b0});
        repeat (plen)     m_wave.push_back({1'b1, m_q, c, 1'b1});
        repeat (TB_HOLD)  m_wave.push_back({1'b1, nq, c, 1'b0});
        m_wave.push_back({1'b0, nq, 2'b00, 1'b0});
    endtask

    task automatic check_all();
        check_eq("j", j, m_cur[2]);
        check_eq("k", k, m_cur[1]);
        check_eq("enable", enable, m_cur[0]);
        check_eq("q_model", q_model, m_cur[3]);
        check_eq("busy", busy, m_cur[4] || (m_fifo.size() != 0));
        check_eq("cmd_ready", cmd_ready, m_rdy && (m_fifo.size() < TB_DEPTH));
    endtask

    task automatic step(input logic v, input logic [1:0] c, output logic acc);
        cmd_valid = v;
        cmd       = c;
        acc = v && m_rdy && (m_fifo.size() < TB_DEPTH);
        @(posedge clk);
        if (m_wave.size() == 0 && m_fifo.size() != 0) m_expand(m_fifo.pop_front());
        if (m_wave.size() != 0) m_cur = m_wave.pop_front();
        else m_cur = {1'b0, m_q, 3'b000};
        m_q = m_cur[3];
        if (acc) m_fifo.push_back(c);
        m_rdy = 1'b1;
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, acc);
    endtask

    task automatic push_cmd(input logic [1:0] c);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) step(1'b1, c, acc);
        cmd_valid = 1'b0;
        check_eq("push_accepted", acc, 1'b1);
    endtask

    initial begin
        logic acc;
        logic [1:0] burst [5];
        burst[0] = 2'b01; burst[1] = 2'b10; burst[2] = 2'b11;
        burst[3] = 2'b00; burst[4] = 2'b10;
        m_reset();
        @(negedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;

        push_cmd(2'b10);
        idle(12);
        push_cmd(2'b11);
        idle(10);
        push_cmd(2'b11);
        idle(10);
        for (int i = 0; i < 5; i++) push_cmd(burst[i]);
        idle(50);

        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), acc);
        end
        cmd_valid = 1'b0;
        idle(60);

        // Reset in the middle of a pulse with commands still queued
        push_cmd(2'b10);
        push_cmd(2'b01);
        push_cmd(2'b10);
        push_cmd(2'b11);
        acc = enable;
        for (int i = 0; i < 30 && !acc; i++) begin
            idle(1);
            acc = enable;
        end
        check_eq("pulse_seen", acc, 1'b1);
        rst_n = 1'b0;
        #1;
        m_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        idle(25);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jk_drive_sequencer.md
JK_DRIVE_SEQUENCER -- requirements
Module: jk_drive_sequencer

Interface
REQ-001 SHALL have parameter SETUP_CYCLES, default 1, meaning cycles j/k are stable before enable rises (range 1..15).
REQ-002 SHALL have parameter PULSE_CYCLES, default 2, meaning enable high-time for non-toggle commands (range 1..15).
REQ-003 SHALL have parameter HOLD_CYCLES, default 1, meaning cycles j/k are held after enable falls (range 1..15).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, meaning command buffer entries (power of two, 2..16).
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port cmd_valid  input  1  command offered.
REQ-008 SHALL have port cmd  input  2  command {j,k}: 00 hold, 01 reset, 10 set, 11 toggle.
REQ-009 SHALL have port cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a rising edge.
REQ-010 SHALL have ports j, k, enable  output  1 each  drive to the downstream JK latch.
REQ-011 SHALL have port busy  output  1  FIFO non-empty or FSM not IDLE.
REQ-012 SHALL have port q_model  output  1  predicted latch q (see Configuration).

Function
REQ-013 SHALL assert cmd_ready = !fifo_full, combinationally from registered FIFO state; a push while full SHALL NOT occur.
REQ-014 SHALL run FSM IDLE -> SETUP -> PULSE -> HOLD -> IDLE, all outputs registered.
REQ-015 In IDLE with FIFO non-empty, SHALL pop one entry, load j/k from it, and enter SETUP on the same edge.
REQ-016 In SETUP, SHALL drive enable=0 with j/k stable for SETUP_CYCLES cycles, then enter PULSE.
REQ-017 In PULSE, SHALL drive enable=1 for PULSE_CYCLES cycles; toggle (11) SHALL use exactly 1 cycle regardless of PULSE_CYCLES, preventing latch oscillation.
REQ-018 In HOLD, SHALL drive enable=0 with j/k unchanged for HOLD_CYCLES cycles, then return to IDLE.
REQ-019 In IDLE, SHALL drive j=k=enable=0.
REQ-020 Latency: command accepted at edge t into empty FIFO while IDLE SHALL give j/k valid after edge t+1 and enable high after edge t+1+SETUP_CYCLES.
REQ-021 Back-to-back: HOLD->IDLE->SETUP SHALL insert exactly one IDLE cycle between commands.
REQ-022 Hold command (00) SHALL still be fully sequenced (enable pulse with j=k=0).
REQ-023 Simultaneous push and pop SHALL both take effect; occupancy unchanged.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter SHALL be log2(FIFO_DEPTH)+1 bits.

Reset
REQ-025 rst_n low SHALL immediately force enable=0, j=0, k=0, q_model=0, FSM=IDLE, FIFO empty, cmd_ready=0; cmd_ready SHALL rise on the first edge after deassertion.
REQ-026 Reset mid-sequence SHALL abandon the current command and flush all buffered commands.

Configuration
REQ-027 With JK_DRV_MODEL_EN defined, q_model SHALL update on the PULSE->HOLD edge: 00 unchanged, 01 ->0, 10 ->1, 11 ->inverted.
REQ-028 Without JK_DRV_MODEL_EN, q_model SHALL be constant 0 and no model register SHALL be synthesised.

Structure
REQ-029 Package jk_drv_pkg SHALL hold the FSM state enum and command constants CMD_HOLD, CMD_RESET, CMD_SET, CMD_TOGGLE.
REQ-030 The command buffer SHALL be sub-module jk_cmd_fifo (push/pop/full/empty, 2-bit data, parameterised depth).

Verification
REQ-031 Defaults, single cmd 10 at t -> j=1,k=0 after t+1; enable high after t+2 and t+3; enable low t+4; j/k 0 after t+5; q_model=1.
REQ-032 Cmd 11 with PULSE_CYCLES=4 -> enable high exactly 1 cycle; q_model toggles 0->1, second toggle ->0.
REQ-033 Push 5 commands back-to-back while IDLE -> cmd_ready low once 4 buffered; all 5 emitted in order 01,10,11,00,10.
REQ-034 Assert rst_n low during PULSE with 3 queued -> enable=0 asynchronously; after release no further pulses, busy=0.
REQ-035 Push during the IDLE pop cycle with FIFO holding 1 -> occupancy stays 1; both commands sequenced with one IDLE gap.
